// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial A+B+c_in / A-B through one shared FA slice, LSB first, WIDTH clocks per op.
// Latency: accept edge loads operands, then WIDTH RUN cycles; out_valid rises on the edge closing the last RUN cycle.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. `define SERIAL_ADD_OVF_EN adds the ovf output.

// One-bit full adder; the only arithmetic in the block.
module serial_add_fa (
   input  logic fa_a,
   input  logic fa_b,
   input  logic fa_ci,
   output logic fa_s,
   output logic fa_co
);
   assign fa_s  = fa_a ^ fa_b ^ fa_ci;
   assign fa_co = (fa_a & fa_b) | (fa_ci & (fa_a ^ fa_b));
endmodule

module serial_add_ctrl #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [CNT_W-1:0] cnt;
   logic             carry_r;
   logic             sub_r;

   logic             fa_sum;
   logic             fa_cout;
   logic             accept;
   logic             last_bit;

   // Subtraction is A + ~B + 1: B is inverted bit by bit and the +1 comes from the preset carry.
   serial_add_fa u_fa (
      .fa_a  (a_sh[0]),
      .fa_b  (b_sh[0] ^ sub_r),
      .fa_ci (carry_r),
      .fa_s  (fa_sum),
      .fa_co (fa_cout)
   );

   assign accept   = in_valid && in_ready;
   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   // Next-state and handshake outputs; operands are only taken in IDLE, results only offered in DONE.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (last_bit) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Operand load on accept, then one bit per clock: shift operands out LSB first, result in from the MSB end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         res_sh  <= '0;
         cnt     <= '0;
         carry_r <= 1'b0;
         sub_r   <= 1'b0;
      end else if (accept) begin
         a_sh    <= a;
         b_sh    <= b;
         sub_r   <= sub;
         carry_r <= sub ? 1'b1 : c_in;
         cnt     <= '0;
         res_sh  <= '0;
      end else if (state == S_RUN) begin
         res_sh  <= {fa_sum, res_sh[WIDTH-1:1]};
         carry_r <= fa_cout;
         a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
         b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
         cnt     <= cnt + CNT_W'(1);
      end
   end

   // Registers stop moving outside RUN, so the result and final carry stay stable for the consumer.
   assign sum   = res_sh;
   assign c_out = carry_r;

`ifdef SERIAL_ADD_OVF_EN
   logic ovf_r;

   // Signed overflow: carry into the MSB (carry_r) differs from carry out of it, sampled on the MSB cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_r <= 1'b0;
      end else if ((state == S_RUN) && last_bit) begin
         ovf_r <= carry_r ^ fa_cout;
      end
   end

   assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed vectors for the 8-bit and 2-bit builds of serial_add_ctrl.
// Latency: each op is checked for the exact accept-to-out_valid edge count.
// Backpressure: result stability and input blocking are checked while out_ready is held low.
module tb_serial_add_ctrl;

   logic       clk;
   logic       rst_n;

   logic       in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out;
   logic [7:0] a, b, sum;

   logic       in_valid2, in_ready2, c_in2, sub2, out_valid2, out_ready2, c_out2;
   logic [1:0] a2, b2, sum2;

`ifdef SERIAL_ADD_OVF_EN
   logic       ovf, ovf2;
`endif

   int checks;
   int errors;

   serial_add_ctrl #(.WIDTH(8)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   serial_add_ctrl #(.WIDTH(2)) u_dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid2),
      .in_ready  (in_ready2),
      .a         (a2),
      .b         (b2),
      .c_in      (c_in2),
      .sub       (sub2),
      .out_valid (out_valid2),
      .out_ready (out_ready2),
      .sum       (sum2),
      .c_out     (c_out2)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf       (ovf2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point for the whole bench.
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Full 8-bit transaction: present, wait for accept, count edges to out_valid, check, release.
   // The accept edge is the first edge counted, so an 8-bit op shows out_valid after edge 9.
   task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tci, input logic tsub,
                        input logic [7:0] esum, input logic ecout, input logic eovf);
      int n;
      a = ta; b = tb; c_in = tci; sub = tsub; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'd9);
      chk({tag, "_sum"}, 32'(sum), 32'(esum));
      chk({tag, "_c_out"}, 32'(c_out), 32'(ecout));
`ifdef SERIAL_ADD_OVF_EN
      chk({tag, "_ovf"}, 32'(ovf), 32'(eovf));
`else
      if (eovf === 1'bx) $display("note: %s has no ovf expectation", tag);
`endif
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_released"}, 32'(out_valid), 32'd0);
      chk({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int n;
      checks = 0; errors = 0;
      rst_n = 1'b0;
      in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
      in_valid2 = 1'b0; a2 = '0; b2 = '0; c_in2 = 1'b0; sub2 = 1'b0; out_ready2 = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset state
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_c_out", 32'(c_out), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef SERIAL_ADD_OVF_EN
      chk("rst_ovf", 32'(ovf), 32'd0);
`endif

      // Add cases
      do_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b1 ^ 1'b1, 1'b1);
      do_op("add_ff_01_ci", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
      do_op("add_ff_00_ci", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

      // Subtract cases, c_in held at 1 to show it is ignored
      do_op("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
      do_op("sub_10_10", 8'h10, 8'h10, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
      do_op("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);

      // Backpressure: first op 0x12+0x34, second (0x70-0x0F) held on the input throughout DONE
      a = 8'h12; b = 8'h34; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
      chk("bp_first_rdy", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      a = 8'h70; b = 8'h0F; sub = 1'b1;
      n = 1;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("bp_latency", 32'(n), 32'd9);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_hold_sum_%0d", i), 32'(sum), 32'h46);
         chk($sformatf("bp_hold_cout_%0d", i), 32'(c_out), 32'd0);
         chk($sformatf("bp_hold_vld_%0d", i), 32'(out_valid), 32'd1);
         chk($sformatf("bp_hold_rdy_%0d", i), 32'(in_ready), 32'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_release_vld", 32'(out_valid), 32'd0);
      chk("bp_release_rdy", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_second_running", 32'(in_ready), 32'd0);
      n = 1;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("bp_second_latency", 32'(n), 32'd9);
      chk("bp_second_sum", 32'(sum), 32'h61);
      chk("bp_second_cout", 32'(c_out), 32'd1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Asynchronous reset in the middle of RUN (cnt=3), 0xAA+0x55 leaves ones in the partial result
      a = 8'hAA; b = 8'h55; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
      chk("ar_accept_rdy", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_sum_zero", 32'(sum), 32'd0);
      chk("ar_cout_zero", 32'(c_out), 32'd0);
      chk("ar_vld_zero", 32'(out_valid), 32'd0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      #1;
      chk("ar_in_ready", 32'(in_ready), 32'd1);
      do_op("ar_add_01_01", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

      // 2-bit build: 3+1 wraps to 0 with carry, out_valid after edge 3 counting the accept edge
      a2 = 2'b11; b2 = 2'b01; c_in2 = 1'b0; sub2 = 1'b0; in_valid2 = 1'b1;
      chk("w2_in_ready", 32'(in_ready2), 32'd1);
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      n = 1;
      while (!out_valid2 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk("w2_latency", 32'(n), 32'd3);
      chk("w2_sum", 32'(sum2), 32'd0);
      chk("w2_c_out", 32'(c_out2), 32'd1);
`ifdef SERIAL_ADD_OVF_EN
      chk("w2_ovf", 32'(ovf2), 32'd0);
`endif
      out_ready2 = 1'b1;
      @(posedge clk); #1;
      out_ready2 = 1'b0;
      chk("w2_released", 32'(out_valid2), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
